vga_sprite_tx: RTL and testbench

//  SVGA 800x600 transmit side of the VGA path. Generates sync timing and
//  h/v counts, and drives the output pixel: camera passthrough, or the

---
 rtl/vga_sprite_tx.sv | 185 ++++++++++++++++++
 tb/tb_vga_sprite_tx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_tx.sv
// SVGA transmit timing plus camera/sprite pixel mux; counts -> pixel/syncs = 2 clocks, no backpressure.
// Define VGA_TEST_PATTERN_EN to replace the camera path with eight vertical colour bars.
module vga_sprite_tx #(
  parameter int          H_SYNC_CYC   = 128,
  parameter int          H_SYNC_BACK  = 88,
  parameter int          H_SYNC_ACT   = 800,
  parameter int          H_SYNC_TOTAL = 1056,
  parameter int          V_SYNC_CYC   = 4,
  parameter int          V_SYNC_BACK  = 23,
  parameter int          V_SYNC_ACT   = 600,
  parameter int          V_SYNC_TOTAL = 628,
  parameter int          BOX_X0       = 100,
  parameter int          BOX_SIZE     = 200,
  parameter logic [23:0] KEY_RGB      = 24'hFF00FF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [9:0]         i_red,
  input  logic [9:0]         i_green,
  input  logic [9:0]         i_blue,
  input  logic               i_en_pokemon,
  input  logic               i_anime,
  input  logic [23:0]        i_sprite_data,
  output logic [14:0]        o_sprite_addr,
  output logic signed [12:0] o_h_count,
  output logic signed [12:0] o_v_count,
  output logic               o_refresh,
  output logic               o_hsync_n,
  output logic               o_vsync_n,
  output logic               o_blank_n,
  output logic [9:0]         o_red,
  output logic [9:0]         o_green,
  output logic [9:0]         o_blue
);

  localparam logic [12:0] H_LAST  = 13'(H_SYNC_TOTAL - 1);
  localparam logic [12:0] V_LAST  = 13'(V_SYNC_TOTAL - 1);
  localparam logic [12:0] H_SC    = 13'(H_SYNC_CYC);
  localparam logic [12:0] V_SC    = 13'(V_SYNC_CYC);
  localparam logic [12:0] X_ST    = 13'(H_SYNC_CYC + H_SYNC_BACK);
  localparam logic [12:0] Y_ST    = 13'(V_SYNC_CYC + V_SYNC_BACK);
  localparam logic [12:0] X_END   = 13'(H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT);
  localparam logic [12:0] Y_END   = 13'(V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT);
  localparam logic [12:0] COL_CLR = 13'(H_SYNC_CYC + H_SYNC_BACK + BOX_X0 - 1);
  localparam logic [7:0]  BOX_LAST = 8'(BOX_SIZE - 1);
  localparam logic [13:0] SPR_W   = 14'(BOX_SIZE / 2);

  logic [12:0] h_q, h_d, v_q, v_d;
  logic [7:0]  col_q, col_d, row_q, row_d;
  logic        frame_q, frame_d;
  logic        refresh, act0, hs0, vs0;
  logic        en1_q, act1_q, hs1_q, vs1_q;
  logic [29:0] pix_q, pix_d;
  logic        hs2_q, vs2_q, blank2_q;
  logic [9:0]  cam_r, cam_g, cam_b;
  logic [6:0]  spr_col, spr_row;

  function automatic logic [9:0] widen8(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

  assign refresh = (h_q == H_LAST) && (v_q == V_LAST);
  assign act0    = (h_q >= X_ST) && (h_q < X_END) && (v_q >= Y_ST) && (v_q < Y_END);
  assign hs0     = (h_q >= H_SC);
  assign vs0     = (v_q >= V_SC);

  // Box counters step by one per pixel/line, so the 2x upscale is just a right shift.
  assign spr_col = col_q[7:1];
  assign spr_row = row_q[7:1];
  assign o_sprite_addr = {frame_q, 14'(spr_row) * SPR_W + 14'(spr_col)};

  always_comb begin
    h_d     = h_q + 13'd1;
    v_d     = v_q;
    col_d   = col_q + 8'd1;
    row_d   = row_q;
    frame_d = frame_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 13'd1;
      if (v_q == V_LAST)
        row_d = '0;
      else if (v_q >= Y_ST)
        row_d = (row_q == BOX_LAST) ? '0 : row_q + 8'd1;
    end
    if (h_q == COL_CLR || col_q == BOX_LAST)
      col_d = '0;
    // Frame select only moves at frame end so a sprite never tears.
    if (refresh)
      frame_d = i_anime;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      col_q   <= col_d;
      row_q   <= row_d;
      frame_q <= frame_d;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_SYNC_ACT / 8;
  logic [12:0] h1_q, bar_x;
  logic [2:0]  bar_idx;

  assign bar_x = h1_q - X_ST;

  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++)
      if (bar_x >= 13'(k * BAR_W))
        bar_idx = 3'(k);
  end

  // Bar order white, yellow, cyan, green, magenta, red, blue, black.
  assign cam_r = {10{~bar_idx[1]}};
  assign cam_g = {10{~bar_idx[2]}};
  assign cam_b = {10{~bar_idx[0]}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) h1_q <= '0;
    else          h1_q <= h_q;
  end
`else
  assign cam_r = i_red;
  assign cam_g = i_green;
  assign cam_b = i_blue;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en1_q  <= 1'b0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else begin
      en1_q  <= i_en_pokemon;
      act1_q <= act0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
    end
  end

  always_comb begin
    pix_d = '0;
    if (act1_q) begin
      if (en1_q && i_sprite_data != KEY_RGB)
        pix_d = {widen8(i_sprite_data[23:16]), widen8(i_sprite_data[15:8]),
                 widen8(i_sprite_data[7:0])};
      else
        pix_d = {cam_r, cam_g, cam_b};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_q    <= '0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b0;
    end else begin
      pix_q    <= pix_d;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      blank2_q <= act1_q;
    end
  end

  assign o_h_count = h_q;
  assign o_v_count = v_q;
  assign o_refresh = refresh;
  assign o_hsync_n = hs2_q;
  assign o_vsync_n = vs2_q;
  assign o_blank_n = blank2_q;
  assign {o_red, o_green, o_blue} = pix_q;

endmodule

// File: tb/tb_vga_sprite_tx.sv
// Bench for vga_sprite_tx on a shrunken raster (80x26 total) so whole frames fit in a short run.
module tb_vga_sprite_tx;
  localparam int HSC = 8,  HB = 4, HA = 64, HT = 80;
  localparam int VSC = 2,  VB = 3, VA = 20, VT = 26;
  localparam int BX0 = 8,  BS = 16, SW = BS / 2;
  localparam int XS = HSC + HB, YS = VSC + VB, FR = HT * VT;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic               i_clk = 1'b0, i_rst_n;
  logic [9:0]         i_red, i_green, i_blue;
  logic               i_en_pokemon, i_anime;
  logic [23:0]        i_sprite_data;
  logic [14:0]        o_sprite_addr;
  logic signed [12:0] o_h_count, o_v_count;
  logic               o_refresh, o_hsync_n, o_vsync_n, o_blank_n;
  logic [9:0]         o_red, o_green, o_blue;

  vga_sprite_tx #(
    .H_SYNC_CYC(HSC), .H_SYNC_BACK(HB), .H_SYNC_ACT(HA), .H_SYNC_TOTAL(HT),
    .V_SYNC_CYC(VSC), .V_SYNC_BACK(VB), .V_SYNC_ACT(VA), .V_SYNC_TOTAL(VT),
    .BOX_X0(BX0), .BOX_SIZE(BS), .KEY_RGB(KEY)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .i_en_pokemon(i_en_pokemon), .i_anime(i_anime), .i_sprite_data(i_sprite_data),
    .o_sprite_addr(o_sprite_addr), .o_h_count(o_h_count), .o_v_count(o_v_count),
    .o_refresh(o_refresh), .o_hsync_n(o_hsync_n), .o_vsync_n(o_vsync_n),
    .o_blank_n(o_blank_n), .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [29:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
  } exp_t;

  int          n_cmp = 0, n_bad = 0;
  int          cyc, mh, mv;
  logic        mframe, m_anime, anime_drv, en_enable, en_drv, m_refresh;
  logic        cam_const_en, rom_force_en;
  logic [9:0]  cam_const;
  logic [23:0] rom_force_val, rom_q;
  logic [29:0] cam_prev;
  logic [14:0] m_addr;
  exp_t        sb[$];
  exp_t        sb_out;
  bit          sb_vld;

  function automatic logic [9:0] wid(input logic [7:0] c);
    return {c, c[7:6]};
  endfunction

  function automatic logic [23:0] rom_fn(input logic [14:0] a);
    if (rom_force_en) return rom_force_val;
    if (a[1:0] == 2'b11) return KEY;
    return {a[7:0] ^ 8'hA5, a[14:7], a[7:0] + 8'd17};
  endfunction

  // Sprite ROM with one cycle of read latency.
  always @(posedge i_clk) rom_q <= rom_fn(o_sprite_addr);
  assign i_sprite_data = rom_q;

  // Drive inputs for the current model position and queue the pixel expected 2 clocks later.
  task automatic drive_now();
    int          col, row;
    logic        act;
    logic [29:0] cam_cur;
    logic [23:0] spr;
    exp_t        e;
    act       = mh >= XS && mh < XS + HA && mv >= YS && mv < YS + VA;
    en_drv    = en_enable && act && mh >= XS + BX0 && mh < XS + BX0 + 2 * BS;
    m_refresh = (mh == HT - 1) && (mv == VT - 1);
    m_anime   = anime_drv;
    m_addr    = '0;
    if (en_drv) begin
      col    = (mh - (XS + BX0)) % BS;
      row    = (mv - YS) % BS;
      m_addr = {mframe, 14'((row / 2) * SW + col / 2)};
    end
    cam_cur = cam_const_en ? {cam_const, cam_const, cam_const}
                           : {10'(mh * 5 + mv), 10'(mh ^ (mv << 3)), 10'(1023 - mh - mv)};
    {i_red, i_green, i_blue} = cam_prev;
    cam_prev     = cam_cur;
    i_en_pokemon = en_drv;
    i_anime      = m_anime;
    spr    = rom_fn(m_addr);
    e.rgb  = '0;
    if (act)
      e.rgb = (en_drv && spr != KEY) ? {wid(spr[23:16]), wid(spr[15:8]), wid(spr[7:0])} : cam_cur;
    e.hs = !(mh < HSC);
    e.vs = !(mv < VSC);
    e.bl = act;
    sb.push_back(e);
    sb_vld = 1'b0;
    if (sb.size() == 3) begin
      sb_out = sb.pop_front();
      sb_vld = 1'b1;
    end
  endtask

  task automatic restart_model();
    cyc = 0; mh = 0; mv = 0; mframe = 1'b0; cam_prev = '0;
    sb.delete();
    drive_now();
  endtask

  task automatic advance();
    @(posedge i_clk);
    if (m_refresh) mframe = m_anime;
    cyc++;
    mh = cyc % HT;
    mv = (cyc / HT) % VT;
    @(negedge i_clk);
    drive_now();
  endtask

  task automatic goto_pos(input int x, input int y, output bit ok);
    for (int i = 0; i < 2 * FR && !(mh == x && mv == y); i++) advance();
    ok = (mh == x && mv == y);
  endtask

  task automatic goto_refresh(output bit ok);
    for (int i = 0; i < 2 * FR && !m_refresh; i++) advance();
    ok = m_refresh;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1; anime_drv = 1'b0; en_enable = 1'b0; cam_const_en = 1'b0;
    rom_force_en = 1'b0; cam_const = '0; rom_force_val = '0;
    {i_red, i_green, i_blue} = '0; i_en_pokemon = 1'b0; i_anime = 1'b0;
    #2 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if ({o_h_count, o_v_count, o_refresh} !== 27'd0) begin
      n_bad++; $display("FAIL reset_counts: h=%0d v=%0d refresh=%b, want 0 0 0", o_h_count, o_v_count, o_refresh);
    end
    n_cmp++;
    if ({o_hsync_n, o_vsync_n, o_blank_n} !== 3'b110) begin
      n_bad++; $display("FAIL reset_syncs: hs/vs/blank=%b%b%b, want 110", o_hsync_n, o_vsync_n, o_blank_n);
    end
    n_cmp++;
    if ({o_red, o_green, o_blue, o_sprite_addr} !== 45'd0) begin
      n_bad++; $display("FAIL reset_pixel: rgb=%h addr=%h, want 0 0", {o_red, o_green, o_blue}, o_sprite_addr);
    end
    i_rst_n = 1'b1;
    restart_model();
    #1;
    n_cmp++;
    if (o_h_count !== 13'd0 || o_v_count !== 13'd0) begin
      n_bad++; $display("FAIL release_counts: h=%0d v=%0d, want 0 0", o_h_count, o_v_count);
    end
    advance();
    n_cmp++;
    if ({o_hsync_n, o_vsync_n, o_blank_n} !== 3'b110 || {o_red, o_green, o_blue} !== 30'd0) begin
      n_bad++; $display("FAIL pipe_fill: hs/vs/blank=%b%b%b rgb=%h, want 110 0", o_hsync_n, o_vsync_n, o_blank_n, {o_red, o_green, o_blue});
    end
    advance();
    n_cmp++;
    if (!sb_vld || {o_red, o_green, o_blue, o_hsync_n, o_vsync_n, o_blank_n} !== sb_out) begin
      n_bad++; $display("FAIL first_pixel: got %h, want %h", {o_red, o_green, o_blue, o_hsync_n, o_vsync_n, o_blank_n}, sb_out);
    end
  endtask

  task automatic test_frame_timing();
    int n_ref = 0, hs_low = 0;
    en_enable = 1'b0; cam_const_en = 1'b0;
    while (cyc < 2 * FR + 4) begin
      advance();
      n_cmp++;
      if (o_h_count !== 13'(mh) || o_v_count !== 13'(mv)) begin
        n_bad++; $display("FAIL counts: h=%0d v=%0d, want %0d %0d", o_h_count, o_v_count, mh, mv);
      end
      n_cmp++;
      if (o_refresh !== m_refresh) begin
        n_bad++; $display("FAIL refresh: got %b at cycle %0d, want %b", o_refresh, cyc, m_refresh);
      end
      if (o_refresh === 1'b1) begin
        n_ref++;
        n_cmp++;
        if (cyc != n_ref * FR - 1) begin
          n_bad++; $display("FAIL refresh_period: pulse %0d at cycle %0d, want %0d", n_ref, cyc, n_ref * FR - 1);
        end
      end
      if (cyc >= 3 * HT + 2 && cyc < 4 * HT + 2 && o_hsync_n === 1'b0) hs_low++;
      if (sb_vld) begin
        n_cmp++;
        if ({o_red, o_green, o_blue, o_hsync_n, o_vsync_n, o_blank_n} !== sb_out) begin
          n_bad++; $display("FAIL timing_pixel: cycle %0d got %h, want %h", cyc, {o_red, o_green, o_blue, o_hsync_n, o_vsync_n, o_blank_n}, sb_out);
        end
      end
    end
    n_cmp++;
    if (n_ref != 2) begin
      n_bad++; $display("FAIL refresh_count: got %0d pulses, want 2", n_ref);
    end
    n_cmp++;
    if (hs_low != HSC) begin
      n_bad++; $display("FAIL hsync_width: low for %0d clocks, want %0d", hs_low, HSC);
    end
  endtask

  task automatic test_passthrough();
    bit ok;
    en_enable = 1'b0; cam_const_en = 1'b1; cam_const = 10'h155;
    goto_pos(XS, YS, ok);
    advance(); advance();
    n_cmp++;
    if (!ok || {o_red, o_green, o_blue} !== {10'h155, 10'h155, 10'h155} || o_blank_n !== 1'b1) begin
      n_bad++; $display("FAIL passthrough: rgb=%h blank=%b reached=%b, want 155 x3 blank 1", {o_red, o_green, o_blue}, o_blank_n, ok);
    end
  endtask

  task automatic test_sprite();
    bit ok1, ok2;
    anime_drv = 1'b1; en_enable = 1'b1; cam_const_en = 1'b0;
    rom_force_en = 1'b1; rom_force_val = 24'h102030;
    goto_refresh(ok1);
    advance();
    goto_pos(XS + BX0, YS, ok2);
    n_cmp++;
    if (!ok1 || !ok2 || o_sprite_addr !== 15'h4000) begin
      n_bad++; $display("FAIL sprite_addr: got %h, want 4000", o_sprite_addr);
    end
    advance(); advance();
    n_cmp++;
    if ({o_red, o_green, o_blue} !== {10'h040, 10'h080, 10'h0C0}) begin
      n_bad++; $display("FAIL sprite_pixel: rgb=%h %h %h, want 040 080 0c0", o_red, o_green, o_blue);
    end
  endtask

  task automatic test_key();
    bit ok;
    rom_force_val = KEY; cam_const_en = 1'b1; cam_const = 10'h2AA;
    goto_pos(XS + BX0 + 3, YS + 2, ok);
    advance(); advance();
    n_cmp++;
    if (!ok || {o_red, o_green, o_blue} !== {10'h2AA, 10'h2AA, 10'h2AA} || o_blank_n !== 1'b1) begin
      n_bad++; $display("FAIL key_transparent: rgb=%h blank=%b, want 2aa x3 blank 1", {o_red, o_green, o_blue}, o_blank_n);
    end
  endtask

  task automatic test_anime_latch();
    bit ok1, ok2, ok3;
    anime_drv = 1'b0;
    goto_pos(XS + BX0, YS + 4, ok1);
    n_cmp++;
    if (!ok1 || o_sprite_addr !== {1'b1, 14'(2 * SW)}) begin
      n_bad++; $display("FAIL anime_midframe: addr=%h, want %h", o_sprite_addr, {1'b1, 14'(2 * SW)});
    end
    goto_refresh(ok2);
    advance();
    goto_pos(XS + BX0, YS, ok3);
    n_cmp++;
    if (!ok2 || !ok3 || o_sprite_addr !== 15'h0000) begin
      n_bad++; $display("FAIL anime_next_frame: addr=%h, want 0000", o_sprite_addr);
    end
  endtask

  task automatic test_back_to_back();
    rom_force_en = 1'b0; cam_const_en = 1'b0; en_enable = 1'b1;
    for (int i = 0; i < FR + 200; i++) begin
      if (i % 300 == 0) anime_drv = 1'($urandom_range(0, 1));
      advance();
      if (en_drv) begin
        n_cmp++;
        if (o_sprite_addr !== m_addr) begin
          n_bad++; $display("FAIL b2b_addr: h=%0d v=%0d addr=%h, want %h", mh, mv, o_sprite_addr, m_addr);
        end
      end
      if (i >= 3 && sb_vld) begin
        n_cmp++;
        if ({o_red, o_green, o_blue, o_hsync_n, o_vsync_n, o_blank_n} !== sb_out) begin
          n_bad++; $display("FAIL b2b_pixel: cycle %0d got %h, want %h", cyc, {o_red, o_green, o_blue, o_hsync_n, o_vsync_n, o_blank_n}, sb_out);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    bit ok;
    goto_pos(30, YS + 1, ok);
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok || {o_h_count, o_v_count, o_refresh, o_sprite_addr} !== 42'd0) begin
      n_bad++; $display("FAIL midline_counts: h=%0d v=%0d addr=%h, want 0 0 0", o_h_count, o_v_count, o_sprite_addr);
    end
    n_cmp++;
    if ({o_hsync_n, o_vsync_n, o_blank_n} !== 3'b110 || {o_red, o_green, o_blue} !== 30'd0) begin
      n_bad++; $display("FAIL midline_outputs: hs/vs/blank=%b%b%b rgb=%h, want 110 0", o_hsync_n, o_vsync_n, o_blank_n, {o_red, o_green, o_blue});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    restart_model();
    repeat (5) advance();
    n_cmp++;
    if (o_h_count !== 13'd5 || o_v_count !== 13'd0) begin
      n_bad++; $display("FAIL midline_restart: h=%0d v=%0d, want 5 0", o_h_count, o_v_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame_timing();
    test_passthrough();
    test_sprite();
    test_key();
    test_anime_latch();
    test_back_to_back();
    test_reset_midline();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
